istate_trap_seq: RTL and testbench

Controller that owns the write and read ports of the internal-state register file (4-bit privilege level plus three architectural registers at addresses 1–3).
- Sequences multi-cycle trap entry and trap return: save EPC, save status, switch privilege; then restore privilege and return PC.
- Arbitrates these sequences against single-cycle software state writes.
- Sits between the pipeline control/exception logic and the internal-state file.

---
 rtl/istate_pkg.sv | 36 +++
 rtl/istate_trap_seq_if.sv | 54 +++++
 rtl/istate_req_arb.sv | 30 +++
 rtl/istate_trap_seq.sv | 197 +++++++++++++++++++
 tb/tb_istate_trap_seq.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/istate_pkg.sv
// Shared types and constants for the internal-state trap sequencer: FSM states,
// register-file addresses, ESTAT field layout and arbiter grant positions.
package istate_pkg;

   localparam int IS_ADDR_W = 6;
   localparam int PL_W      = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SW,
      ST_T_EPC,
      ST_T_STAT,
      ST_T_PL,
      ST_R_STAT,
      ST_R_PC
   } state_e;

   localparam logic [IS_ADDR_W-1:0] IS_ADDR_NONE    = 6'd0;
   localparam logic [IS_ADDR_W-1:0] IS_ADDR_EPC     = 6'd1;
   localparam logic [IS_ADDR_W-1:0] IS_ADDR_ESTAT   = 6'd2;
   localparam logic [IS_ADDR_W-1:0] IS_ADDR_SCRATCH = 6'd3;

   // ESTAT holds the cause at the bottom and the saved privilege level just above it.
   localparam int ESTAT_CAUSE_LSB = 0;

   localparam logic [PL_W-1:0] KERNEL_PL_DEFAULT = 4'h0;

   localparam int GNT_TRAP = 0;
   localparam int GNT_RET  = 1;
   localparam int GNT_SW   = 2;

   function automatic logic is_arch_addr(input logic [IS_ADDR_W-1:0] addr);
      return (addr >= IS_ADDR_EPC) && (addr <= IS_ADDR_SCRATCH);
   endfunction

endpackage

// File: rtl/istate_trap_seq_if.sv
// Request/response and internal-state-file signals of the trap sequencer.
// master = pipeline plus state file side, slave = the sequencer.
interface istate_trap_seq_if #(
   parameter int DATA_W  = 64,
   parameter int CAUSE_W = 8
);
   logic               sw_valid;
   logic               sw_ready;
   logic               sw_is_pl;
   logic [5:0]         sw_addr;
   logic [DATA_W-1:0]  sw_data;

   logic               trap_valid;
   logic               trap_ready;
   logic [CAUSE_W-1:0] trap_cause;
   logic [DATA_W-1:0]  trap_pc;

   logic               ret_valid;
   logic               ret_ready;
   logic               ret_done;
   logic [DATA_W-1:0]  ret_pc;

   logic               is_wr_en;
   logic [5:0]         is_wr_addr;
   logic [DATA_W-1:0]  is_wr_data;
   logic               is_wr_pl_en;
   logic [3:0]         is_wr_pl_data;
   logic [5:0]         is_rd_addr;
   logic [DATA_W-1:0]  is_rd_data;
   logic [3:0]         is_pl;

   logic               busy;
   logic               in_trap;
   logic               double_fault;

   modport master (
      output sw_valid, sw_is_pl, sw_addr, sw_data,
      output trap_valid, trap_cause, trap_pc, ret_valid,
      output is_rd_data, is_pl,
      input  sw_ready, trap_ready, ret_ready, ret_done, ret_pc,
      input  is_wr_en, is_wr_addr, is_wr_data, is_wr_pl_en, is_wr_pl_data, is_rd_addr,
      input  busy, in_trap, double_fault
   );

   modport slave (
      input  sw_valid, sw_is_pl, sw_addr, sw_data,
      input  trap_valid, trap_cause, trap_pc, ret_valid,
      input  is_rd_data, is_pl,
      output sw_ready, trap_ready, ret_ready, ret_done, ret_pc,
      output is_wr_en, is_wr_addr, is_wr_data, is_wr_pl_en, is_wr_pl_data, is_rd_addr,
      output busy, in_trap, double_fault
   );

endinterface

// File: rtl/istate_req_arb.sv
// Fixed-priority request arbiter (trap > ret > sw), active only while the
// sequencer is idle; produces the ready strobes and a one-hot grant.
module istate_req_arb
   import istate_pkg::*;
(
   input  logic       en_i,
   input  logic       trap_valid_i,
   input  logic       ret_valid_i,
   input  logic       sw_valid_i,
   output logic       trap_ready_o,
   output logic       ret_ready_o,
   output logic       sw_ready_o,
   output logic [2:0] grant_o
);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
      grant_o = '0;
      if (en_i) begin
         if (trap_valid_i)     grant_o[GNT_TRAP] = 1'b1;
         else if (ret_valid_i) grant_o[GNT_RET]  = 1'b1;
         else if (sw_valid_i)  grant_o[GNT_SW]   = 1'b1;
      end
   end

   assign trap_ready_o = grant_o[GNT_TRAP];
   assign ret_ready_o  = grant_o[GNT_RET];
   assign sw_ready_o   = grant_o[GNT_SW];

endmodule

// File: rtl/istate_trap_seq.sv
// Trap entry / trap return sequencer owning the internal-state file ports.
// Optional macro ISTATE_NESTED_TRAP_EN enables a 2-bit trap nesting depth.
module istate_trap_seq
   import istate_pkg::*;
#(
   parameter int              DATA_W    = 64,
   parameter int              CAUSE_W   = 8,
   parameter logic [PL_W-1:0] KERNEL_PL = KERNEL_PL_DEFAULT
) (
   input logic               clk,
   input logic               rst,
   istate_trap_seq_if.slave  bus
);

   localparam int ESTAT_PL_LSB = ESTAT_CAUSE_LSB + CAUSE_W;

   state_e               state_q, state_d;
   logic [2:0]           grant;
   logic                 in_trap;
   logic                 trap_blocked;
   logic                 trap_take;

   logic [CAUSE_W-1:0]   cause_q;
   logic [DATA_W-1:0]    pc_q;
   logic [PL_W-1:0]      saved_pl_q;
   logic                 sw_is_pl_q;
   logic [IS_ADDR_W-1:0] sw_addr_q;
   logic [DATA_W-1:0]    sw_data_q;
   logic [PL_W-1:0]      estat_pl_q;
   logic                 ret_nop_q, ret_nop_d;
   logic                 double_fault_q, double_fault_d;

   logic [DATA_W-1:0]    estat_w;
   logic                 wr_en, pl_en, ret_done;
   logic [IS_ADDR_W-1:0] wr_addr, rd_addr;
   logic [DATA_W-1:0]    wr_data, ret_pc;
   logic [PL_W-1:0]      pl_data;

   istate_req_arb u_arb (
      .en_i         (state_q == ST_IDLE),
      .trap_valid_i (bus.trap_valid),
      .ret_valid_i  (bus.ret_valid),
      .sw_valid_i   (bus.sw_valid),
      .trap_ready_o (bus.trap_ready),
      .ret_ready_o  (bus.ret_ready),
      .sw_ready_o   (bus.sw_ready),
      .grant_o      (grant)
   );

`ifdef ISTATE_NESTED_TRAP_EN
   logic [1:0] depth_q;

   assign in_trap      = (depth_q != 2'd0);
   assign trap_blocked = (depth_q == 2'd3);

   always_ff @(posedge clk) begin
      if (rst)                     depth_q <= 2'd0;
      else if (state_q == ST_T_PL) depth_q <= depth_q + 2'd1;
      else if (state_q == ST_R_PC) depth_q <= depth_q - 2'd1;
   end
`else
   logic in_trap_q;

   assign in_trap      = in_trap_q;
   assign trap_blocked = in_trap_q;

   always_ff @(posedge clk) begin
      if (rst)                     in_trap_q <= 1'b0;
      else if (state_q == ST_T_PL) in_trap_q <= 1'b1;
      else if (state_q == ST_R_PC) in_trap_q <= 1'b0;
   end
`endif

   assign trap_take = grant[GNT_TRAP] && !trap_blocked;

   always_ff @(posedge clk) begin
      // NOTE: the payload registers are reset too, so an abandoned sequence leaves no stale capture behind.
      if (rst) begin
         state_q        <= ST_IDLE;
         cause_q        <= '0;
         pc_q           <= '0;
         saved_pl_q     <= '0;
         sw_is_pl_q     <= 1'b0;
         sw_addr_q      <= '0;
         sw_data_q      <= '0;
         estat_pl_q     <= '0;
         ret_nop_q      <= 1'b0;
         double_fault_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
         state_q        <= state_d;
         ret_nop_q      <= ret_nop_d;
         double_fault_q <= double_fault_d;
         if (trap_take) begin
            cause_q    <= bus.trap_cause;
            pc_q       <= bus.trap_pc;
            saved_pl_q <= bus.is_pl;
         end
         if (grant[GNT_SW]) begin
            sw_is_pl_q <= bus.sw_is_pl;
            sw_addr_q  <= bus.sw_addr;
            sw_data_q  <= bus.sw_data;
         end
         if (state_q == ST_R_STAT) estat_pl_q <= bus.is_rd_data[ESTAT_PL_LSB +: PL_W];
      end
   end

   always_comb begin
      estat_w = '0;
      estat_w[ESTAT_CAUSE_LSB +: CAUSE_W] = cause_q;
      estat_w[ESTAT_PL_LSB +: PL_W]       = saved_pl_q;
   end

   always_comb begin
      state_d        = state_q;
      ret_nop_d      = 1'b0;
      double_fault_d = double_fault_q;
      wr_en          = 1'b0;
      wr_addr        = IS_ADDR_NONE;
      wr_data        = '0;
      pl_en          = 1'b0;
      pl_data        = '0;
      rd_addr        = IS_ADDR_NONE;
      ret_done       = 1'b0;
      ret_pc         = '0;

      unique case (state_q)
         ST_IDLE: begin
            // A return with no trap in flight completes here one cycle after accept, with ret_pc = 0.
            ret_done = ret_nop_q;
            if (grant[GNT_TRAP]) begin
               if (trap_blocked) double_fault_d = 1'b1;
               else              state_d        = ST_T_EPC;
            end else if (grant[GNT_RET]) begin
               if (in_trap) state_d   = ST_R_STAT;
               else         ret_nop_d = 1'b1;
            end else if (grant[GNT_SW]) begin
               state_d = ST_SW;
            end
         end
         ST_SW: begin
            if (sw_is_pl_q) begin
               pl_en   = (bus.is_pl == KERNEL_PL);
               pl_data = sw_data_q[PL_W-1:0];
            end else begin
               wr_en   = is_arch_addr(sw_addr_q);
               wr_addr = sw_addr_q;
               wr_data = sw_data_q;
            end
            state_d = ST_IDLE;
         end
         ST_T_EPC: begin
            wr_en   = 1'b1;
            wr_addr = IS_ADDR_EPC;
            wr_data = pc_q;
            state_d = ST_T_STAT;
         end
         ST_T_STAT: begin
            wr_en   = 1'b1;
            wr_addr = IS_ADDR_ESTAT;
            wr_data = estat_w;
            state_d = ST_T_PL;
         end
         ST_T_PL: begin
            pl_en   = 1'b1;
            pl_data = KERNEL_PL;
            state_d = ST_IDLE;
         end
         ST_R_STAT: begin
            rd_addr = IS_ADDR_ESTAT;
            state_d = ST_R_PC;
         end
         ST_R_PC: begin
            rd_addr  = IS_ADDR_EPC;
            pl_en    = 1'b1;
            pl_data  = estat_pl_q;
            ret_done = 1'b1;
            ret_pc   = bus.is_rd_data;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.is_wr_en      = wr_en;
   assign bus.is_wr_addr    = wr_addr;
   assign bus.is_wr_data    = wr_data;
   assign bus.is_wr_pl_en   = pl_en;
   assign bus.is_wr_pl_data = pl_data;
   assign bus.is_rd_addr    = rd_addr;
   assign bus.ret_done      = ret_done;
   assign bus.ret_pc        = ret_pc;
   assign bus.busy          = (state_q != ST_IDLE);
   assign bus.in_trap       = in_trap;
   assign bus.double_fault  = double_fault_q;

endmodule

// File: tb/tb_istate_trap_seq.sv
// Scoreboard bench for istate_trap_seq: directed requests push expected writes,
// privilege updates and return completions; a negedge monitor pops and compares.
module tb_istate_trap_seq;
   import istate_pkg::*;

   localparam int DATA_W  = 64;
   localparam int CAUSE_W = 8;

   typedef enum logic [1:0] {EV_WR, EV_PL, EV_RET} ev_e;
   typedef struct packed {
      ev_e         kind;
      logic [5:0]  addr;
      logic [63:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic mon_en = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   istate_trap_seq_if #(.DATA_W(DATA_W), .CAUSE_W(CAUSE_W)) bus ();

   istate_trap_seq #(.DATA_W(DATA_W), .CAUSE_W(CAUSE_W), .KERNEL_PL(4'h0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Internal-state file model: regs 1..3 plus privilege level, reset with the DUT.
   logic [DATA_W-1:0] regs [0:3];
   logic [3:0]        model_pl;
   logic              poke_en = 1'b0;
   logic [3:0]        poke_pl = 4'h0;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) regs[i] <= '0;
         model_pl <= 4'h0;
      end else begin
         if (bus.is_wr_en && bus.is_wr_addr >= 6'd1 && bus.is_wr_addr <= 6'd3)
            regs[bus.is_wr_addr[1:0]] <= bus.is_wr_data;
         if (poke_en)               model_pl <= poke_pl;
         else if (bus.is_wr_pl_en)  model_pl <= bus.is_wr_pl_data;
      end
   end

   assign bus.is_rd_data = (bus.is_rd_addr < 6'd4) ? regs[bus.is_rd_addr[1:0]] : '0;
   assign bus.is_pl      = model_pl;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic sb_match(input ev_e kind, input logic [5:0] addr, input logic [63:0] data);
      exp_t e;
      check("sb_expected_event", {63'd0, sb_q.size() != 0}, 64'd1);
      if (sb_q.size() == 0) return;
      e = sb_q.pop_front();
      check("sb_kind", {62'd0, kind}, {62'd0, e.kind});
      check("sb_addr", {58'd0, addr}, {58'd0, e.addr});
      check("sb_data", data, e.data);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         check("wr_exclusive", {63'd0, bus.is_wr_en & bus.is_wr_pl_en}, 64'd0);
         if (bus.is_wr_en)    sb_match(EV_WR, bus.is_wr_addr, bus.is_wr_data);
         if (bus.is_wr_pl_en) sb_match(EV_PL, 6'd0, {60'd0, bus.is_wr_pl_data});
         if (bus.ret_done)    sb_match(EV_RET, 6'd0, bus.ret_pc);
      end
   end

   task automatic exp_wr(input logic [5:0] a, input logic [63:0] d);
      sb_q.push_back('{kind: EV_WR, addr: a, data: d});
   endtask

   task automatic exp_pl(input logic [3:0] p);
      sb_q.push_back('{kind: EV_PL, addr: 6'd0, data: {60'd0, p}});
   endtask

   task automatic exp_ret(input logic [63:0] pc);
      sb_q.push_back('{kind: EV_RET, addr: 6'd0, data: pc});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for the selected ready; 0 = trap, 1 = ret, 2 = sw.
   task automatic wait_accept(input int which, input string name, output int waits);
      logic r, others;
      waits = 0;
      r = 1'b0;
      others = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         case (which)
            0:       begin r = bus.trap_ready; others = bus.ret_ready  | bus.sw_ready;  end
            1:       begin r = bus.ret_ready;  others = bus.trap_ready | bus.sw_ready;  end
            default: begin r = bus.sw_ready;   others = bus.trap_ready | bus.ret_ready; end
         endcase
         if (r) break;
         waits++;
         step();
      end
      check({name, "_ready"}, {63'd0, r}, 64'd1);
      check({name, "_one_ready"}, {63'd0, others}, 64'd0);
      step();
   endtask

   task automatic issue_sw(input logic is_pl, input logic [5:0] addr, input logic [63:0] data,
                           input string name, output int waits);
      bus.sw_is_pl = is_pl;
      bus.sw_addr  = addr;
      bus.sw_data  = data;
      bus.sw_valid = 1'b1;
      wait_accept(2, name, waits);
      bus.sw_valid = 1'b0;
   endtask

   task automatic issue_trap(input logic [7:0] cause, input logic [63:0] pc,
                             input string name, output int waits);
      bus.trap_cause = cause;
      bus.trap_pc    = pc;
      bus.trap_valid = 1'b1;
      wait_accept(0, name, waits);
      bus.trap_valid = 1'b0;
   endtask

   task automatic issue_ret(input string name, output int waits);
      bus.ret_valid = 1'b1;
      wait_accept(1, name, waits);
      bus.ret_valid = 1'b0;
   endtask

   task automatic set_pl(input logic [3:0] p);
      poke_pl = p;
      poke_en = 1'b1;
      step();
      poke_en = 1'b0;
   endtask

   task automatic check_idle(input string name);
      check({name, "_busy"},         {63'd0, bus.busy},         64'd0);
      check({name, "_in_trap"},      {63'd0, bus.in_trap},      64'd0);
      check({name, "_double_fault"}, {63'd0, bus.double_fault}, 64'd0);
      check({name, "_wr_en"},        {63'd0, bus.is_wr_en},     64'd0);
      check({name, "_pl_en"},        {63'd0, bus.is_wr_pl_en},  64'd0);
      check({name, "_ret_done"},     {63'd0, bus.ret_done},     64'd0);
      check({name, "_rd_addr"},      {58'd0, bus.is_rd_addr},   64'd0);
      check({name, "_ret_pc"},       bus.ret_pc,                64'd0);
      check({name, "_readies"},      {61'd0, bus.trap_ready, bus.ret_ready, bus.sw_ready}, 64'd0);
   endtask

   // SW cycle of a request that must be dropped.
   task automatic check_dropped(input string name);
      @(negedge clk);
      check({name, "_busy"},  {63'd0, bus.busy},        64'd1);
      check({name, "_wr_en"}, {63'd0, bus.is_wr_en},    64'd0);
      check({name, "_pl_en"}, {63'd0, bus.is_wr_pl_en}, 64'd0);
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      bus.sw_valid   = 1'b0;
      bus.sw_is_pl   = 1'b0;
      bus.sw_addr    = '0;
      bus.sw_data    = '0;
      bus.trap_valid = 1'b0;
      bus.trap_cause = '0;
      bus.trap_pc    = '0;
      bus.ret_valid  = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);
      check_idle("reset");
      step();

      // Software register write to scratch.
      exp_wr(IS_ADDR_SCRATCH, 64'hAB);
      issue_sw(1'b0, 6'd3, 64'hAB, "sw_scratch", w);
      check("sw_scratch_wait", w, 0);
      @(negedge clk);
      check("sw_scratch_wr_en", {63'd0, bus.is_wr_en}, 64'd1);
      step();

      // Kernel sets privilege level 2.
      exp_pl(4'h2);
      issue_sw(1'b1, 6'd0, 64'h2, "sw_pl2", w);
      step();

      // Trap entry from PL 2.
      exp_wr(IS_ADDR_EPC, 64'h1000);
      exp_wr(IS_ADDR_ESTAT, 64'h20D);
      exp_pl(4'h0);
      issue_trap(8'h0D, 64'h1000, "trap1", w);
      check("trap1_wait", w, 0);
      repeat (3) step();
      @(negedge clk);
      check("trap1_busy_done", {63'd0, bus.busy},    64'd0);
      check("trap1_in_trap",   {63'd0, bus.in_trap}, 64'd1);
      step();

      // Trap return.
      exp_pl(4'h2);
      exp_ret(64'h1000);
      issue_ret("ret1", w);
      @(negedge clk);
      check("ret1_rstat_addr", {58'd0, bus.is_rd_addr}, 64'd2);
      step();
      @(negedge clk);
      check("ret1_rpc_addr", {58'd0, bus.is_rd_addr}, 64'd1);
      check("ret1_done",     {63'd0, bus.ret_done},   64'd1);
      step();
      @(negedge clk);
      check("ret1_in_trap", {63'd0, bus.in_trap}, 64'd0);
      check("ret1_idle",    {63'd0, bus.busy},    64'd0);
      step();

      // All three requests at once: trap, then ret, then sw.
      exp_wr(IS_ADDR_EPC, 64'h2000);
      exp_wr(IS_ADDR_ESTAT, 64'h221);
      exp_pl(4'h0);
      exp_pl(4'h2);
      exp_ret(64'h2000);
      exp_wr(IS_ADDR_SCRATCH, 64'h55);
      bus.trap_cause = 8'h21;
      bus.trap_pc    = 64'h2000;
      bus.trap_valid = 1'b1;
      bus.ret_valid  = 1'b1;
      bus.sw_is_pl   = 1'b0;
      bus.sw_addr    = 6'd3;
      bus.sw_data    = 64'h55;
      bus.sw_valid   = 1'b1;
      @(negedge clk);
      check("prio_trap_ready", {63'd0, bus.trap_ready}, 64'd1);
      check("prio_ret_ready",  {63'd0, bus.ret_ready},  64'd0);
      check("prio_sw_ready",   {63'd0, bus.sw_ready},   64'd0);
      step();
      bus.trap_valid = 1'b0;
      wait_accept(1, "prio_ret", w);
      check("prio_ret_wait", w, 3);
      bus.ret_valid = 1'b0;
      wait_accept(2, "prio_sw", w);
      bus.sw_valid = 1'b0;
      step();

      // Dropped software requests: PL write outside kernel, addresses 0 and 7.
      set_pl(4'h3);
      issue_sw(1'b1, 6'd0, 64'h1, "drop_pl", w);
      check_dropped("drop_pl");
      issue_sw(1'b0, 6'd0, 64'h11, "drop_a0", w);
      check_dropped("drop_a0");
      issue_sw(1'b0, 6'd7, 64'h22, "drop_a7", w);
      check_dropped("drop_a7");

      // Trap from PL 3, then a second trap while in the handler.
      exp_wr(IS_ADDR_EPC, 64'h3000);
      exp_wr(IS_ADDR_ESTAT, 64'h342);
      exp_pl(4'h0);
      issue_trap(8'h42, 64'h3000, "trap3", w);
      repeat (3) step();
      @(negedge clk);
      check("trap3_in_trap", {63'd0, bus.in_trap}, 64'd1);
      step();
      issue_trap(8'h55, 64'h4000, "dfault", w);
      check("dfault_wait", w, 0);
      @(negedge clk);
      check("dfault_busy", {63'd0, bus.busy},         64'd0);
      check("dfault_flag", {63'd0, bus.double_fault}, 64'd1);
      step();
      repeat (4) step();
      @(negedge clk);
      check("dfault_sticky", {63'd0, bus.double_fault}, 64'd1);
      step();

      // Return from the first handler, then a return with no trap in flight.
      exp_pl(4'h3);
      exp_ret(64'h3000);
      issue_ret("ret3", w);
      repeat (2) step();
      @(negedge clk);
      check("ret3_in_trap", {63'd0, bus.in_trap}, 64'd0);
      step();
      exp_ret(64'h0);
      issue_ret("ret_nop", w);
      @(negedge clk);
      check("ret_nop_done", {63'd0, bus.ret_done}, 64'd1);
      check("ret_nop_pc",   bus.ret_pc,            64'd0);
      check("ret_nop_busy", {63'd0, bus.busy},     64'd0);
      check("ret_nop_dfault_kept", {63'd0, bus.double_fault}, 64'd1);
      step();

      // Reset during T_STAT abandons the sequence.
      exp_wr(IS_ADDR_EPC, 64'h5000);
      exp_wr(IS_ADDR_ESTAT, 64'h30A);
      issue_trap(8'h0A, 64'h5000, "trap_rst", w);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      check_idle("mid_reset");
      step();
      repeat (3) step();

      check("sb_drained", sb_q.size(), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
